// File: rtl/digit_field_mapper_if.sv
// digit_field_mapper_if: bus between readout controller/scan source and the mapper.
// master: drives writes, commit, scan position, frame_start; slave: the mapper.
interface digit_field_mapper_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic [7:0] character_code;
  logic [9:0] char_start_x;
  logic [9:0] char_start_y;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       in_field;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output commit,
    output x,
    output y,
    output frame_start,
    input  commit_pending,
    input  character_code,
    input  char_start_x,
    input  char_start_y,
    input  x_out,
    input  y_out,
    input  in_field
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  commit,
    input  x,
    input  y,
    input  frame_start,
    output commit_pending,
    output character_code,
    output char_start_x,
    output char_start_y,
    output x_out,
    output y_out,
    output in_field
  );
endinterface

// File: rtl/digit_field_mapper.sv
// digit_field_mapper: double-buffered character row feeding a 16x32 glyph renderer.
// Maps scan (x, y) to the tile under it; shadow row is published at frame_start.
//
// Ports: clk, reset (async, active-high), bus (digit_field_mapper_if.slave):
//   wr_en/wr_addr/wr_data  shadow write
//   commit / commit_pending  publish request and its pending flag
//   x, y, frame_start      scan position and frame boundary pulse
//   character_code, char_start_x, char_start_y, x_out, y_out, in_field
//                          registered mapping, one clock after x, y
// Option: define LEADING_ZERO_BLANK_EN to blank leading zero slots at publish.
module digit_field_mapper #(
  parameter int         NUM_CHARS  = 8,
  parameter logic [9:0] ORIGIN_X   = 10'd64,
  parameter logic [9:0] ORIGIN_Y   = 10'd32,
  parameter logic [7:0] BLANK_CODE = 8'hFF
) (
  input logic                 clk,
  input logic                 reset,
  digit_field_mapper_if.slave bus
);

  if (NUM_CHARS < 1 || NUM_CHARS > 16) begin : g_bad_num
    $error("NUM_CHARS must be 1..16");
  end

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  // Field limits in 11 bits so ORIGIN + extent cannot wrap.
  localparam logic [10:0] X_BEG = {1'b0, ORIGIN_X};
  localparam logic [10:0] X_END = X_BEG + 11'(16 * NUM_CHARS);
  localparam logic [10:0] Y_BEG = {1'b0, ORIGIN_Y};
  localparam logic [10:0] Y_END = Y_BEG + 11'd32;

  logic [7:0] shadow [NUM_CHARS];
  logic [7:0] active [NUM_CHARS];
  logic [7:0] tile_code [NUM_CHARS];

  logic [0:0] state;
  logic [0:0] state_nx;
  logic       publish;

  // ---------------- publish control ----------------
  // A commit arriving with frame_start while idle publishes at once.
  always_comb begin
    publish = bus.frame_start &&
              ((state == S_PEND) || bus.commit);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (bus.commit && !bus.frame_start)
          state_nx = S_PEND;
      end
      S_PEND: begin
        if (bus.frame_start)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  assign bus.commit_pending = (state == S_PEND);

  // ---------------- shadow / active buffers ----------------
  // Slots at or beyond NUM_CHARS never match, so such writes drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++)
        shadow[i] <= BLANK_CODE;
    end else begin
      for (int i = 0; i < NUM_CHARS; i++)
        if (bus.wr_en && bus.wr_addr == 4'(i))
          shadow[i] <= bus.wr_data;
    end
  end

  // Copy reads shadow before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++)
        active[i] <= BLANK_CODE;
    end else if (publish) begin
      for (int i = 0; i < NUM_CHARS; i++)
        active[i] <= shadow[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_CHARS-1:0] blank_mask;
  logic [NUM_CHARS-1:0] mask_nx;

  // Slot i blanks while every slot 0..i is zero; last slot never blanks.
  always_comb begin
    logic run;
    run     = 1'b1;
    mask_nx = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      run        = run && (shadow[i] == 8'd0);
      mask_nx[i] = run && (i < NUM_CHARS - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      blank_mask <= '0;
    else if (publish)
      blank_mask <= mask_nx;
  end

  always_comb begin
    for (int i = 0; i < NUM_CHARS; i++)
      tile_code[i] = blank_mask[i] ? BLANK_CODE : active[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CHARS; i++)
      tile_code[i] = active[i];
  end
`endif

  // ---------------- scan mapping ----------------
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        in_x;
  logic        in_y;
  logic        in_f;
  logic [9:0]  x_off;
  logic [9:0]  tile_off;
  logic [7:0]  code_nx;
  logic [9:0]  sx_nx;
  logic [9:0]  sy_nx;

  always_comb begin
    x_ext = {1'b0, bus.x};
    y_ext = {1'b0, bus.y};
    in_x  = (x_ext >= X_BEG) && (x_ext < X_END);
    in_y  = (y_ext >= Y_BEG) && (y_ext < Y_END);
    in_f  = in_x && in_y;
  end

  // Offset only formed once x >= ORIGIN_X; masking the low
  // nibble gives col*16 without a separate shift.
  always_comb begin
    x_off    = in_x ? (bus.x - ORIGIN_X) : 10'd0;
    tile_off = x_off & ~10'h00F;
  end

  always_comb begin
    code_nx = BLANK_CODE;
    sx_nx   = '0;
    sy_nx   = '0;
    if (in_f) begin
      sx_nx = ORIGIN_X + tile_off;
      sy_nx = ORIGIN_Y;
      for (int i = 0; i < NUM_CHARS; i++)
        if (tile_off == 10'(16 * i))
          code_nx = tile_code[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.character_code <= BLANK_CODE;
      bus.char_start_x   <= '0;
      bus.char_start_y   <= '0;
      bus.x_out          <= '0;
      bus.y_out          <= '0;
      bus.in_field       <= 1'b0;
    end else begin
      bus.character_code <= code_nx;
      bus.char_start_x   <= sx_nx;
      bus.char_start_y   <= sy_nx;
      bus.x_out          <= bus.x;
      bus.y_out          <= bus.y;
      bus.in_field       <= in_f;
    end
  end

endmodule

// File: tb/tb_digit_field_mapper.sv
// tb_digit_field_mapper: scoreboard bench for digit_field_mapper.
// Stimulus pushes expected mapping results; a negedge monitor pops and compares.
module tb_digit_field_mapper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_field_mapper_if bus();

  digit_field_mapper #(
    .NUM_CHARS (8),
    .ORIGIN_X  (10'd64),
    .ORIGIN_Y  (10'd32),
    .BLANK_CODE(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] code;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       inf;
    logic [9:0] xo;
    logic [9:0] yo;
    logic       pchk;
    logic       pend;
  } exp_t;

  exp_t       q[$];
  exp_t       me;
  logic [7:0] act_m [8];
  logic       chk_en = 1'b0;
  logic       chk_q = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mexp(logic [9:0] xi, logic [9:0] yi,
                                bit pc, bit pe);
    exp_t e;
    int   c;
    e.xo   = xi;
    e.yo   = yi;
    e.pchk = pc;
    e.pend = pe;
    if (xi >= 64 && xi < 192 && yi >= 32 && yi < 64) begin
      c      = (int'(xi) - 64) / 16;
      e.code = act_m[c];
      e.sx   = 10'(64 + 16 * c);
      e.sy   = 10'd32;
      e.inf  = 1'b1;
    end else begin
      e.code = 8'hFF;
      e.sx   = '0;
      e.sy   = '0;
      e.inf  = 1'b0;
    end
    return e;
  endfunction

  task automatic cyc(logic [9:0] xi, logic [9:0] yi, bit fs, bit cm,
                     bit we, logic [3:0] wa, logic [7:0] wd,
                     bit sc, bit pc, bit pe);
    @(posedge clk);
    #1;
    bus.x           = xi;
    bus.y           = yi;
    bus.frame_start = fs;
    bus.commit      = cm;
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    chk_en          = sc;
    if (sc) q.push_back(mexp(xi, yi, pc, pe));
  endtask

  task automatic idle();
    cyc(10'd0, 10'd0, 0, 0, 0, 4'd0, 8'd0, 0, 0, 0);
  endtask

  task automatic scan(logic [9:0] xi, logic [9:0] yi);
    cyc(xi, yi, 0, 0, 0, 4'd0, 8'd0, 1, 0, 0);
  endtask

  task automatic scanp(logic [9:0] xi, bit pe);
    cyc(xi, 10'd40, 0, 0, 0, 4'd0, 8'd0, 1, 1, pe);
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    cyc(10'd0, 10'd0, 0, 0, 1, a, d, 0, 0, 0);
  endtask

  // commit / frame_start pulse with a sampled scan position
  task automatic ev(bit fs, bit cm, logic [9:0] xi, bit pe);
    cyc(xi, 10'd40, fs, cm, 0, 4'd0, 8'd0, 1, 1, pe);
  endtask

  task automatic scan_slots();
    for (int c = 0; c < 8; c++) scan(10'(64 + 16 * c + 5), 10'd50);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  always @(posedge clk) chk_q <= chk_en;

  always @(negedge clk) begin
    if (chk_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: output with no expectation at %0t", $time);
      end else begin
        me = q.pop_front();
        chk("code", bus.character_code, me.code);
        chk("sx", bus.char_start_x, me.sx);
        chk("sy", bus.char_start_y, me.sy);
        chk("in_field", bus.in_field, me.inf);
        chk("x_out", bus.x_out, me.xo);
        chk("y_out", bus.y_out, me.yo);
        if (me.pchk) chk("pending", bus.commit_pending, me.pend);
      end
    end
  end

  initial begin
    logic [7:0] d1 [8];
    logic [7:0] d2 [8];
    logic [7:0] lz [8];
    d1 = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    d2 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    for (int i = 0; i < 8; i++) act_m[i] = 8'hFF;
    reset           = 1'b1;
    bus.x           = '0;
    bus.y           = '0;
    bus.frame_start = 1'b0;
    bus.commit      = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_code", bus.character_code, 8'hFF);
    chk("rst_sx", bus.char_start_x, 0);
    chk("rst_sy", bus.char_start_y, 0);
    chk("rst_inf", bus.in_field, 0);
    chk("rst_xo", bus.x_out, 0);
    chk("rst_yo", bus.y_out, 0);
    chk("rst_pend", bus.commit_pending, 0);
    reset = 1'b0;

    // reset while pending drops the request
    ev(0, 1, 10'd64, 1);
    idle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pend", bus.commit_pending, 0);
    chk("midrst_code", bus.character_code, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    ev(1, 0, 10'd64, 0);
    scanp(10'd100, 0);
    scan_slots();

    // publish digits and scan the row
    for (int i = 0; i < 8; i++) wr(4'(i), d1[i]);
    ev(0, 1, 10'd64, 1);
    ev(1, 0, 10'd64, 0);
    act_m = d1;
    for (int xv = 60; xv <= 195; xv++) scan(10'(xv), 10'd40);
    scan(10'd100, 10'd31);
    scan(10'd100, 10'd32);
    scan(10'd100, 10'd63);
    scan(10'd100, 10'd64);

    // no tearing without commit
    for (int i = 0; i < 8; i++) wr(4'(i), d2[i]);
    ev(1, 0, 10'd64, 0);
    idle();
    ev(1, 0, 10'd80, 0);
    scan_slots();
    // commit together with frame_start publishes at once
    ev(1, 1, 10'd64, 0);
    act_m = d2;
    scanp(10'd80, 0);
    scan_slots();

    // write in the publish cycle keeps the pre-write value
    wr(4'd2, 8'd1);
    ev(0, 1, 10'd96, 1);
    cyc(10'd96, 10'd40, 1, 0, 1, 4'd2, 8'd7, 1, 1, 0);
    act_m[2] = 8'd1;
    scan(10'd96, 10'd40);
    ev(0, 1, 10'd96, 1);
    ev(1, 0, 10'd96, 0);
    act_m[2] = 8'd7;
    scan(10'd96, 10'd40);

    // out-of-range writes are dropped
    wr(4'd12, 8'h55);
    wr(4'd8, 8'h66);
    wr(4'd15, 8'h77);
    ev(0, 1, 10'd64, 1);
    ev(1, 0, 10'd64, 0);
    scan_slots();

    // leading zero blanking
    lz = '{8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) wr(4'(i), lz[i]);
    ev(0, 1, 10'd64, 1);
    ev(1, 0, 10'd64, 0);
`ifdef LEADING_ZERO_BLANK_EN
    act_m = '{8'hFF, 8'hFF, 8'hFF, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
`else
    act_m = lz;
`endif
    scan_slots();
    wr(4'd3, 8'd0);
    ev(0, 1, 10'd64, 1);
    ev(1, 0, 10'd64, 0);
`ifdef LEADING_ZERO_BLANK_EN
    act_m = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0};
`else
    act_m = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    scan_slots();
    idle();
    drain();

    // reset clears active contents again
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) act_m[i] = 8'hFF;
    scan_slots();
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
